univ_shift_reg_seq: RTL and testbench
=====================================

// Module: univ_shift_reg_seq
// PURPOSE
//  Parametrised universal shift register, WIDTH bits. Single-step ops (hold, shift, load,
//  arithmetic shift, optional rotate), plus sequenced multi-step shift: start/amount ->
//  one step per cycle, busy/done handshake. Datapath element for serialisers and
//  shift-add units in the Task1 block set.
// PARAMETERS
//  WIDTH   8   register width in bits, >= 2
//  AMT_W   $clog2(WIDTH+1)   width of amount port; holds 0..WIDTH
// PORTS
//  clk          in   1       clock, rising edge
//  clr          in   1       reset, asynchronous, active-high
//  en           in   1       single-step enable, honoured only in IDLE
//  mode         in   3       operation code (see BEHAVIOUR)
//  serialright  in   1       serial bit entering MSB on right shift
//  serialleft   in   1       serial bit entering LSB on left shift
//  in           in   WIDTH   parallel load data
//  start        in   1       launch sequenced op, honoured only in IDLE
//  amount       in   AMT_W   steps for sequenced op, sampled with start
//  q            out  WIDTH   register contents
//  busy         out  1       high while sequence runs
//  done         out  1       one-cycle pulse on sequence completion
// BEHAVIOUR
//  - clk is the only clock; clr is asynchronous and active-high.
//  - Reset (async): q=0, busy=0, done=0, FSM=IDLE, step counter=0.
//  - mode: 000 hold; 001 SHR q<={serialright,q[W-1:1]}; 010 SHL q<={q[W-2:0],serialleft};
//    011 LOAD q<=in; 100 ROR q<={q[0],q[W-1:1]}; 101 ROL q<={q[W-2:0],q[W-1]};
//    110 ASR q<={q[W-1],q[W-1:1]}; 111 reserved = hold.
//  - IDLE, start=0, en=1: mode op applied at next edge; latency 1. en=0: hold.
//  - IDLE, start=1: start wins over en. mode and amount latched; amount==0 or
//    LOAD/hold/reserved -> LOAD applies in at that edge (else q unchanged), no RUN, done=1
//    next cycle. Otherwise -> RUN, busy=1 from next cycle.
//  - RUN: one step of latched mode per edge, counter counts down; serialright/serialleft
//    sampled live each step. After amount steps -> IDLE, busy=0, done=1 for one cycle,
//    coincident with final q value.
//  - amount=WIDTH on SHR/SHL: q becomes all serial bits; ROR/ROL by WIDTH: q unchanged.
//  - amount > WIDTH: clamped to WIDTH.
//  - While busy: en, start, mode, amount, in ignored.
//  - clr mid-sequence: immediate abort to reset values; no done pulse.
//  - FSM: IDLE -> RUN (start, valid shift mode, amount>0); RUN -> IDLE (counter==1).
// CONFIGURATION
//  - USR_ROTATE_EN defined: codes 100/101 rotate as above, single-step and sequenced.
//  - Undefined: 100/101 treated as reserved (hold); start with them completes as amount=0.
// STRUCTURE
//  - Package usr_pkg: mode code localparams (MODE_HOLD..MODE_RSVD), FSM state encoding.
//  - Sub-module usr_step: combinational next-q from (q, mode, serialright, serialleft, in);
//    shared by single-step and RUN paths. Top holds q, FSM, counter, done.
// TESTING (WIDTH=8)
//  - clr=1 then 0, load in=8'hA5 mode=011 en=1 -> q=8'hA5 after 1 edge; busy=0, done=0.
//  - q=8'hA5, mode=001 serialright=1 en=1 one edge -> q=8'hD2; mode=010 serialleft=0 -> 8'hA4.
//  - q=8'h81, start mode=110 amount=3 -> busy 3 cycles, q=8'hF0, done pulses once.
//  - USR_ROTATE_EN: q=8'h81, start mode=101 amount=4 -> q=8'h18; without macro q stays 8'h81, done next cycle.
//  - start mode=001 amount=0 -> q unchanged, busy never high, done 1 cycle; start+en same cycle -> start wins.
//  - start mode=010 amount=8, assert clr after 2 steps -> q=0, busy=0, no done; amount=12 clamps to 8.

Source files
------------

// File: rtl/usr_pkg.sv
// usr_pkg: mode codes and FSM state encoding for the universal shift register.
package usr_pkg;
  localparam logic [2:0] MODE_HOLD = 3'b000;
  localparam logic [2:0] MODE_SHR  = 3'b001;
  localparam logic [2:0] MODE_SHL  = 3'b010;
  localparam logic [2:0] MODE_LOAD = 3'b011;
  localparam logic [2:0] MODE_ROR  = 3'b100;
  localparam logic [2:0] MODE_ROL  = 3'b101;
  localparam logic [2:0] MODE_ASR  = 3'b110;
  localparam logic [2:0] MODE_RSVD = 3'b111;
  typedef enum logic {ST_IDLE, ST_RUN} state_t;
endpackage

// File: rtl/usr_step.sv
// usr_step: combinational next-q for one shift/load step; rotates only with USR_ROTATE_EN.
module usr_step
  import usr_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] i_q,
  input  logic [2:0]       i_mode,
  input  logic             i_sr,
  input  logic             i_sl,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);
  logic [WIDTH-1:0] w_ror;
  logic [WIDTH-1:0] w_rol;
`ifdef USR_ROTATE_EN
  assign w_ror = {i_q[0], i_q[WIDTH-1:1]};
  assign w_rol = {i_q[WIDTH-2:0], i_q[WIDTH-1]};
`else
  assign w_ror = i_q;
  assign w_rol = i_q;
`endif
  always_comb begin
    o_q = (i_mode == MODE_SHR)  ? {i_sr, i_q[WIDTH-1:1]} :
          (i_mode == MODE_SHL)  ? {i_q[WIDTH-2:0], i_sl} :
          (i_mode == MODE_LOAD) ? i_d :
          (i_mode == MODE_ROR)  ? w_ror :
          (i_mode == MODE_ROL)  ? w_rol :
          (i_mode == MODE_ASR)  ? {i_q[WIDTH-1], i_q[WIDTH-1:1]} : i_q;
  end
endmodule

// File: rtl/univ_shift_reg_seq.sv
// univ_shift_reg_seq: universal shift register with sequenced multi-step shift.
// Define USR_ROTATE_EN to enable rotate codes 100/101.
module univ_shift_reg_seq
  import usr_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int AMT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic             serialright,
  input  logic             serialleft,
  input  logic [WIDTH-1:0] in,
  input  logic             start,
  input  logic [AMT_W-1:0] amount,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             done
);
  state_t           r_state;
  logic [WIDTH-1:0] r_q;
  logic [AMT_W-1:0] r_cnt;
  logic [2:0]       r_mode;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] w_next;
  logic [AMT_W-1:0] w_amt;
  logic             w_shift_ok;
  assign w_amt = (amount > AMT_W'(WIDTH)) ? AMT_W'(WIDTH) : amount;
`ifdef USR_ROTATE_EN
  assign w_shift_ok = (mode == MODE_SHR) || (mode == MODE_SHL) || (mode == MODE_ASR) ||
                      (mode == MODE_ROR) || (mode == MODE_ROL);
`else
  assign w_shift_ok = (mode == MODE_SHR) || (mode == MODE_SHL) || (mode == MODE_ASR);
`endif
  usr_step #(.WIDTH(WIDTH)) u_step (
    .i_q    (r_q),
    .i_mode ((r_state == ST_RUN) ? r_mode : mode),
    .i_sr   (serialright),
    .i_sl   (serialleft),
    .i_d    (in),
    .o_q    (w_next)
  );
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_state <= ST_IDLE;
      r_q     <= '0;
      r_cnt   <= '0;
      r_mode  <= MODE_HOLD;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (r_state == ST_IDLE) begin
        if (start) begin
          r_mode <= mode;
          if (w_amt == '0 || !w_shift_ok) begin
            r_q    <= (mode == MODE_LOAD) ? in : r_q;
            r_done <= 1'b1;
          end else begin
            r_state <= ST_RUN;
            r_busy  <= 1'b1;
            r_cnt   <= w_amt;
          end
        end else if (en) begin
          r_q <= w_next;
        end
      end else begin
        r_q   <= w_next;
        r_cnt <= r_cnt - AMT_W'(1);
        if (r_cnt == AMT_W'(1)) begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
        end
      end
    end
  end
  assign q    = r_q;
  assign busy = r_busy;
  assign done = r_done;
endmodule

// File: tb/tb_univ_shift_reg_seq.sv
// tb_univ_shift_reg_seq: randomized checks of univ_shift_reg_seq against an arithmetic model.
module tb_univ_shift_reg_seq;
`ifdef USR_ROTATE_EN
  localparam bit ROT = 1'b1;
`else
  localparam bit ROT = 1'b0;
`endif
  logic       clk = 1'b0;
  logic       clr = 1'b1;
  logic       en = 1'b0;
  logic [2:0] mode = 3'd0;
  logic       sr = 1'b0;
  logic       sl = 1'b0;
  logic [7:0] din = 8'd0;
  logic       start = 1'b0;
  logic [3:0] amount = 4'd0;
  logic [7:0] q;
  logic       busy;
  logic       done;
  logic [7:0] mq = 8'd0;
  int pass = 0;
  int total = 0;

  univ_shift_reg_seq #(.WIDTH(8)) dut (
    .clk(clk), .clr(clr), .en(en), .mode(mode), .serialright(sr), .serialleft(sl),
    .in(din), .start(start), .amount(amount), .q(q), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] ref_step(logic [7:0] v, logic [2:0] m, logic r, logic l, logic [7:0] d);
    case (m)
      3'd1: return (v >> 1) | (r ? 8'h80 : 8'h00);
      3'd2: return 8'(v * 2) + (l ? 8'd1 : 8'd0);
      3'd3: return d;
      3'd4: return ROT ? ((v >> 1) | ((v % 2 == 1) ? 8'h80 : 8'h00)) : v;
      3'd5: return ROT ? (8'(v * 2) + ((v >= 8'h80) ? 8'd1 : 8'd0)) : v;
      3'd6: return (v >> 1) | (v & 8'h80);
      default: return v;
    endcase
  endfunction

  task automatic load(input logic [7:0] d);
    start = 0; en = 1; mode = 3'd3; din = d;
    tick;
    en = 0;
    mq = d;
    total++;
    if ({q, busy, done} !== {mq, 2'b00}) $display("FAIL load got=%h exp=%h", {q, busy, done}, {mq, 2'b00});
    else pass++;
  endtask

  task automatic test_reset;
    #12;
    total++;
    if ({q, busy, done} !== 10'd0) $display("FAIL reset got=%h exp=%h", {q, busy, done}, 10'd0);
    else pass++;
    @(negedge clk);
    clr = 0;
    load(8'hA5);
  endtask

  task automatic test_single_ops;
    en = 1; mode = 3'd1; sr = 1;
    tick;
    mq = ref_step(mq, 3'd1, 1'b1, 1'b0, din);
    total++;
    if ({q, busy, done} !== {8'hD2, 2'b00}) $display("FAIL shr got=%h exp=%h", {q, busy, done}, {8'hD2, 2'b00});
    else pass++;
    mode = 3'd2; sl = 0;
    tick;
    mq = ref_step(mq, 3'd2, 1'b1, 1'b0, din);
    total++;
    if ({q, busy, done} !== {8'hA4, 2'b00}) $display("FAIL shl got=%h exp=%h", {q, busy, done}, {8'hA4, 2'b00});
    else pass++;
    en = 0;
  endtask

  task automatic test_random_single;
    for (int i = 0; i < 40; i++) begin
      en = 1'($urandom); mode = 3'($urandom); sr = 1'($urandom); sl = 1'($urandom); din = 8'($urandom);
      tick;
      if (en) mq = ref_step(mq, mode, sr, sl, din);
      total++;
      if ({q, busy, done} !== {mq, 2'b00}) $display("FAIL single_%0d got=%h exp=%h", i, {q, busy, done}, {mq, 2'b00});
      else pass++;
    end
    en = 0;
  endtask

  task automatic run_seq(input string nm, input logic [2:0] m, input logic [3:0] a, input logic [7:0] d);
    int n;
    bit sh;
    n = (a > 8) ? 8 : int'(a);
    sh = (m == 3'd1) || (m == 3'd2) || (m == 3'd6) || (ROT && (m == 3'd4 || m == 3'd5));
    start = 1; en = 1; mode = m; amount = a; din = d;
    tick;
    start = 0;
    if (n == 0 || !sh) begin
      if (m == 3'd3) mq = d;
      total++;
      if ({q, busy, done} !== {mq, 2'b01}) $display("FAIL %s_imm got=%h exp=%h", nm, {q, busy, done}, {mq, 2'b01});
      else pass++;
    end else begin
      total++;
      if ({q, busy, done} !== {mq, 2'b10}) $display("FAIL %s_go got=%h exp=%h", nm, {q, busy, done}, {mq, 2'b10});
      else pass++;
      for (int k = 1; k <= n; k++) begin
        sr = 1'($urandom); sl = 1'($urandom); en = 1'($urandom); start = 1'($urandom);
        mode = 3'($urandom); amount = 4'($urandom); din = 8'($urandom);
        tick;
        mq = ref_step(mq, m, sr, sl, din);
        total++;
        if ({q, busy, done} !== {mq, k < n, k == n})
          $display("FAIL %s_step%0d got=%h exp=%h", nm, k, {q, busy, done}, {mq, k < n, k == n});
        else pass++;
      end
      start = 0;
    end
    en = 0;
    tick;
    total++;
    if ({q, busy, done} !== {mq, 2'b00}) $display("FAIL %s_end got=%h exp=%h", nm, {q, busy, done}, {mq, 2'b00});
    else pass++;
  endtask

  task automatic test_sequences;
    load(8'h81);
    run_seq("asr3", 3'd6, 4'd3, 8'h00);
    total++;
    if (q !== 8'hF0) $display("FAIL asr3_val got=%h exp=%h", q, 8'hF0);
    else pass++;
    load(8'h81);
    run_seq("rol4", 3'd5, 4'd4, 8'h00);
    total++;
    if (q !== (ROT ? 8'h18 : 8'h81)) $display("FAIL rol4_val got=%h exp=%h", q, ROT ? 8'h18 : 8'h81);
    else pass++;
    run_seq("shr0", 3'd1, 4'd0, 8'h00);
    run_seq("ldseq", 3'd3, 4'd5, 8'h3C);
    run_seq("hold", 3'd0, 4'd7, 8'hFF);
    run_seq("shr8", 3'd1, 4'd8, 8'h00);
    run_seq("shl12", 3'd2, 4'd12, 8'h00);
    run_seq("ror8", 3'd4, 4'd8, 8'h00);
  endtask

  task automatic test_random_seq;
    for (int i = 0; i < 12; i++) begin
      if (i % 3 == 0) load(8'($urandom));
      run_seq($sformatf("rseq%0d", i), 3'($urandom), 4'($urandom), 8'($urandom));
    end
  endtask

  task automatic test_clr_abort;
    load(8'h5A);
    start = 1; mode = 3'd2; amount = 4'd8;
    tick;
    start = 0;
    for (int k = 0; k < 2; k++) begin
      sl = 1'($urandom);
      tick;
    end
    #2 clr = 1;
    #1;
    mq = 8'd0;
    total++;
    if ({q, busy, done} !== 10'd0) $display("FAIL clr_abort got=%h exp=%h", {q, busy, done}, 10'd0);
    else pass++;
    tick;
    clr = 0;
    tick;
    total++;
    if ({q, busy, done} !== 10'd0) $display("FAIL clr_nodone got=%h exp=%h", {q, busy, done}, 10'd0);
    else pass++;
  endtask

  initial begin
    test_reset;
    test_single_ops;
    test_random_single;
    test_sequences;
    test_random_seq;
    test_clr_abort;
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
